aes_key_schedule: RTL

- Parametrised iterative AES key expansion supporting AES-128, AES-192 and AES-256, selected per request.
- Generates one 32-bit schedule word per cycle using a single shared SubWord unit.
- Streams the round keys (128 bits each) to the cipher datapath over a valid/ready handshake.
- Sits between key load logic and the round engine; the cipher no longer needs the whole schedule stored.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_sbox.sv | 36 +++
 rtl/aes_key_schedule.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared encodings and small helpers for the iterative AES key schedule.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128  = 2'd0;
  localparam logic [1:0] KEY_LEN_192  = 2'd1;
  localparam logic [1:0] KEY_LEN_256  = 2'd2;
  localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

  typedef enum logic {IDLE, RUN} state_t;

  // Key length in 32-bit words; 0 marks the reserved encoding.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEY_LEN_128:  return 4'd4;
      KEY_LEN_192:  return 4'd6;
      KEY_LEN_256:  return 4'd8;
      KEY_LEN_RSVD: return 4'd0;
      default:      return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEY_LEN_128: return 4'd10;
      KEY_LEN_192: return 4'd12;
      KEY_LEN_256: return 4'd14;
      default:     return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inv = x^2 * x^4 * ... * x^128 = x^254, which maps 0 to 0 as the S-box needs.
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one word per cycle, streaming
// 128-bit round keys over a valid/ready handshake.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int KEY_W  = 32 * MAX_NK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [KEY_W-1:0] keyIn,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_data,
  output logic [3:0]       rk_idx,
  output logic             rk_last,
  output logic             busy,
  output logic             keyExpDone,
  output logic             err
);

  localparam int IW = $clog2(MAX_NK);

  state_t                  state_reg;
  logic [MAX_NK-1:0][31:0] win_reg;
  logic [3:0][31:0]        coll_reg;
  logic [2:0]              coll_cnt_reg;
  logic [5:0]              gen_cnt_reg;
  logic [2:0]              mod_reg;
  logic [7:0]              rcon_reg;
  logic [3:0]              nk_reg, nr_reg, idx_reg;
  logic                    valid_reg, busy_reg, done_reg, err_reg;

  logic [3:0]       req_nk;
  logic             req_ok, handshake, push, key_phase;
  logic [31:0]      oldest, newest, sub_in, sub_out, temp, word;
  logic [5:0]       words_total;
  logic [2:0]       coll_next;
  logic [KEY_W-1:0] key_aligned;

  assign req_nk      = nk_of(key_len);
  assign req_ok      = (req_nk != 4'd0) && (int'(req_nk) <= MAX_NK);
  // Shift the MSB-aligned key so w0..w(Nk-1) land in the top Nk window slots.
  assign key_aligned = keyIn >> (32 * (MAX_NK - int'(req_nk)));

  // Window: slot MAX_NK-1 is the newest word, slot MAX_NK-Nk the oldest.
  assign oldest    = win_reg[IW'(MAX_NK - int'(nk_reg))];
  assign newest    = win_reg[MAX_NK-1];
  assign key_phase = gen_cnt_reg < {2'b00, nk_reg};
  assign sub_in    = (mod_reg == 3'd0) ? {newest[23:0], newest[31:24]} : newest;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (sub_in[8*gi +: 8]),
        .out_byte (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    temp = newest;
    if (mod_reg == 3'd0)
      temp = sub_out ^ {rcon_reg, 24'h0};
    else if (nk_reg == 4'd8 && mod_reg == 3'd4)
      temp = sub_out;
    // During the key phase the window rotates, re-emitting the key words in order.
    word = key_phase ? oldest : (oldest ^ temp);
  end

  assign words_total = {nr_reg, 2'b00} + 6'd4;
  assign handshake   = valid_reg && rk_ready;
  assign push        = (state_reg == RUN) && (gen_cnt_reg < words_total) &&
                       ((coll_cnt_reg != 3'd4) || handshake);
  assign coll_next   = (handshake ? 3'd0 : coll_cnt_reg) + {2'b00, push};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      win_reg      <= '0;
      coll_reg     <= '0;
      coll_cnt_reg <= 3'd0;
      gen_cnt_reg  <= 6'd0;
      mod_reg      <= 3'd0;
      rcon_reg     <= 8'h00;
      nk_reg       <= 4'd0;
      nr_reg       <= 4'd0;
      idx_reg      <= 4'd0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (req_ok) begin
              state_reg    <= RUN;
              busy_reg     <= 1'b1;
              done_reg     <= 1'b0;
              nk_reg       <= req_nk;
              nr_reg       <= nr_of(key_len);
              gen_cnt_reg  <= 6'd0;
              mod_reg      <= 3'd0;
              rcon_reg     <= 8'h01;
              coll_cnt_reg <= 3'd0;
              valid_reg    <= 1'b0;
              idx_reg      <= 4'd0;
              for (int p = 0; p < MAX_NK; p++)
                win_reg[p] <= key_aligned[32*(MAX_NK-1-p) +: 32];
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push) begin
            win_reg     <= {word, win_reg[MAX_NK-1:1]};
            gen_cnt_reg <= gen_cnt_reg + 6'd1;
            mod_reg     <= (mod_reg == 3'(nk_reg - 4'd1)) ? 3'd0 : mod_reg + 3'd1;
            if (!key_phase && mod_reg == 3'd0)
              rcon_reg <= xtime(rcon_reg);
            coll_reg[handshake ? 2'd0 : coll_cnt_reg[1:0]] <= word;
          end
          coll_cnt_reg <= coll_next;
          valid_reg    <= (coll_next == 3'd4);
          if (handshake) begin
            idx_reg <= idx_reg + 4'd1;
            if (idx_reg == nr_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rk_valid   = valid_reg;
  assign rk_data    = {coll_reg[0], coll_reg[1], coll_reg[2], coll_reg[3]};
  assign rk_idx     = idx_reg;
  assign rk_last    = valid_reg && (idx_reg == nr_reg);
  assign busy       = busy_reg;
  assign keyExpDone = done_reg;
  assign err        = err_reg;

endmodule
